// File: rtl/sargantana_icache_pkg.sv
// Shared icache types plus the IFILL responder additions (state enum, beat geometry).
package sargantana_icache_pkg;

  localparam int unsigned PADDR_SIZE = 40;

  // Invalidation request as seen by the icache.
  typedef struct packed {
    logic        valid;
    logic [11:0] paddr;
  } inv_t;

  // Refill request issued by the icache.
  typedef struct packed {
    logic                  valid;
    logic [1:0]            way;
    logic [PADDR_SIZE-1:0] paddr;
  } ifill_req_o_t;

  // Refill response returned to the icache.
  typedef struct packed {
    logic         valid;
    logic         ack;
    logic [255:0] data;
    logic [1:0]   beat;
    inv_t         inv;
  } ifill_resp_i_t;

  localparam int unsigned IFILL_N_BEATS = 4;
  localparam int unsigned IFILL_BEAT_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } ifill_rsp_state_t;

endpackage

// File: rtl/sargantana_ifill_line_buf.sv
// Line assembly buffer: each memory beat lands in its natural slot of the cache line.
module sargantana_ifill_line_buf #(
  parameter int unsigned N_BEATS = 4,
  parameter int unsigned BEAT_W  = 64,
  localparam int unsigned SlotW  = $clog2(N_BEATS)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      wr_en_i,
  input  logic [SlotW-1:0]          start_i,
  input  logic [SlotW-1:0]          rsp_cnt_i,
  input  logic [BEAT_W-1:0]         data_i,
  output logic [N_BEATS*BEAT_W-1:0] line_o
);

  logic [N_BEATS*BEAT_W-1:0] line_d, line_q;
  logic [SlotW-1:0]          slot;

  // Responses arrive in issue order, so the slot is the start word plus the response count.
  always_comb begin
    slot   = start_i + rsp_cnt_i;
    line_d = line_q;
    if (wr_en_i) begin
      line_d[slot*BEAT_W +: BEAT_W] = data_i;
    end
  end

  // Line storage, cleared on reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/sargantana_ifill_responder.sv
// Memory-side IFILL responder: acks a refill request, reads the line as N_BEATS memory beats
// and returns it in a single response pulse; forwards invalidations one cycle later.
// Build option: IFILL_CRITICAL_WORD_FIRST_EN fetches the requested word first.
module sargantana_ifill_responder
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N_BEATS = IFILL_N_BEATS,
  parameter int unsigned BEAT_W  = IFILL_BEAT_W,
  parameter int unsigned PADDR_W = PADDR_SIZE
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  ifill_req_o_t       ifill_req_i,
  output ifill_resp_i_t      ifill_resp_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [PADDR_W-1:0] mem_req_addr_o,
  input  logic               mem_rsp_valid_i,
  input  logic [BEAT_W-1:0]  mem_rsp_data_i,
  input  logic               inv_valid_i,
  input  logic [11:0]        inv_paddr_i
);

  localparam int unsigned SlotW    = $clog2(N_BEATS);
  localparam int unsigned CntW     = $clog2(N_BEATS + 1);
  localparam int unsigned ByteOffW = $clog2(BEAT_W / 8);
  localparam int unsigned LineOffW = SlotW + ByteOffW;
  localparam logic [CntW-1:0] NBeatsC = CntW'(N_BEATS);
  localparam logic [CntW-1:0] LastC   = CntW'(N_BEATS - 1);

  ifill_rsp_state_t    state_d, state_q;
  logic [PADDR_W-1:0]  base_d, base_q;
  logic [SlotW-1:0]    start_d, start_q;
  logic [CntW-1:0]     issue_cnt_d, issue_cnt_q;
  logic [CntW-1:0]     rsp_cnt_d, rsp_cnt_q;
  logic                ack_d, ack_q;
  logic                valid_d, valid_q;
  logic [SlotW-1:0]    beat_d, beat_q;
  inv_t                inv_d, inv_q;
  logic [SlotW-1:0]    req_start;
  logic [SlotW-1:0]    issue_word;
  logic                issue_fire;
  logic                rsp_fire;
  logic [N_BEATS*BEAT_W-1:0] line;
  logic                unused_req;

`ifdef IFILL_CRITICAL_WORD_FIRST_EN
  assign req_start = ifill_req_i.paddr[LineOffW-1:ByteOffW];
`else
  assign req_start = '0;
`endif

  // Way and in-line offset are not needed to fetch a whole line.
  assign unused_req = ^{ifill_req_i.way, ifill_req_i.paddr[LineOffW-1:0]};

  // Issue side: address wraps within the line starting at the latched start word.
  always_comb begin
    issue_word      = start_q + issue_cnt_q[SlotW-1:0];
    mem_req_valid_o = (state_q == FETCH) && (issue_cnt_q < NBeatsC);
    mem_req_addr_o  = mem_req_valid_o ?
                      (base_q | PADDR_W'({issue_word, {ByteOffW{1'b0}}})) : '0;
    issue_fire      = mem_req_valid_o & mem_req_ready_i;
    rsp_fire        = (state_q == FETCH) & mem_rsp_valid_i;
  end

  // Next-state for the FSM, counters and registered response outputs.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    start_d     = start_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    ack_d       = 1'b0;
    valid_d     = 1'b0;
    beat_d      = '0;
    inv_d       = '{valid: inv_valid_i, paddr: inv_paddr_i};
    unique case (state_q)
      IDLE: begin
        if (ifill_req_i.valid) begin
          base_d      = {ifill_req_i.paddr[PADDR_W-1:LineOffW], {LineOffW{1'b0}}};
          start_d     = req_start;
          issue_cnt_d = '0;
          rsp_cnt_d   = '0;
          ack_d       = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (issue_fire) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (rsp_fire) begin
          rsp_cnt_d = rsp_cnt_q + 1'b1;
          if (rsp_cnt_q == LastC) begin
            state_d = RESP;
            valid_d = 1'b1;
            beat_d  = start_q;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      beat_q      <= '0;
      inv_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      start_q     <= start_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      beat_q      <= beat_d;
      inv_q       <= inv_d;
    end
  end

  sargantana_ifill_line_buf #(
    .N_BEATS (N_BEATS),
    .BEAT_W  (BEAT_W)
  ) u_line_buf (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .wr_en_i   (rsp_fire),
    .start_i   (start_q),
    .rsp_cnt_i (rsp_cnt_q[SlotW-1:0]),
    .data_i    (mem_rsp_data_i),
    .line_o    (line)
  );

  assign ifill_resp_o.valid = valid_q;
  assign ifill_resp_o.ack   = ack_q;
  assign ifill_resp_o.data  = line;
  assign ifill_resp_o.beat  = beat_q;
  assign ifill_resp_o.inv   = inv_q;

endmodule

// File: tb/tb_sargantana_ifill_responder.sv
// Self-checking bench for sargantana_ifill_responder with a queue-based memory model.
module tb_sargantana_ifill_responder;
  import sargantana_icache_pkg::*;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  ifill_req_o_t  ifill_req_i = '0;
  ifill_resp_i_t ifill_resp_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i = 1'b0;
  logic [39:0]   mem_req_addr_o;
  logic          mem_rsp_valid_i = 1'b0;
  logic [63:0]   mem_rsp_data_i = '0;
  logic          inv_valid_i = 1'b0;
  logic [11:0]   inv_paddr_i = '0;

  sargantana_ifill_responder dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .ifill_req_i     (ifill_req_i),
    .ifill_resp_o    (ifill_resp_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .inv_valid_i     (inv_valid_i),
    .inv_paddr_i     (inv_paddr_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model configuration and state.
  int          ready_mode = 0;  // 0 always ready, 1 toggle, 2 random
  int          lat = 1;
  int          inv_mode = 0;    // 0 idle, 1 fixed 0xABC, 2 random
  logic [63:0] words [4];
  logic [39:0] issue_log [$];
  logic [39:0] pend_addr [$];
  int          pend_due [$];
  int          rsp_given = 0;
  int          overlap = 0;
  bit          stall_pend = 0;
  logic [39:0] stall_addr = '0;
  logic [12:0] exp_inv = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: accepts on ready, answers in order after lat cycles with the word at that address.
  always @(negedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_addr.delete();
      pend_due.delete();
      stall_pend = 0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i = '0;
    end else begin
      logic r;
      case (ready_mode)
        0: r = 1'b1;
        1: r = ~mem_req_ready_i;
        default: r = 1'($urandom_range(0, 1));
      endcase
      mem_req_ready_i = r;
      if (stall_pend && mem_req_valid_o) chk("addr_hold", 256'(mem_req_addr_o), 256'(stall_addr));
      stall_pend = mem_req_valid_o && !r;
      stall_addr = mem_req_addr_o;
      if (mem_req_valid_o && r) begin
        issue_log.push_back(mem_req_addr_o);
        pend_addr.push_back(mem_req_addr_o);
        pend_due.push_back(cyc + lat);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = words[pend_addr[0][4:3]];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
        rsp_given++;
      end else begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i = {$urandom, $urandom};
      end
      if (ifill_resp_o.ack && ifill_resp_o.valid) overlap++;
    end
  end

  // One cycle: sample after the falling edge, check forwarded invalidation, drive the next one.
  task automatic tick();
    @(negedge clk_i);
    #1;
    chk("inv", 256'(ifill_resp_o.inv), 256'(exp_inv));
    case (inv_mode)
      0: begin inv_valid_i = 1'b0; inv_paddr_i = '0; end
      1: begin inv_valid_i = 1'b1; inv_paddr_i = 12'hABC; end
      default: begin inv_valid_i = 1'($urandom_range(0, 1)); inv_paddr_i = 12'($urandom); end
    endcase
    exp_inv = {inv_valid_i, inv_paddr_i};
  endtask

  task automatic rand_words();
    for (int w = 0; w < 4; w++) words[w] = {$urandom, $urandom};
  endtask

  // One full refill; starts driving valid in the current cycle.
  task automatic fill(input logic [39:0] paddr, input logic [1:0] way, input bit chk_lat,
                      input string tag);
    int t0, t_ack, t_rsp, s;
    bit got;
    logic [39:0] base;
    logic [255:0] line, exp_line;
    logic [1:0] beat;
    base = {paddr[39:5], 5'b0};
`ifdef IFILL_CRITICAL_WORD_FIRST_EN
    s = int'(paddr[4:3]);
`else
    s = 0;
`endif
    for (int w = 0; w < 4; w++) exp_line[w*64 +: 64] = words[w];
    issue_log.delete();
    overlap = 0;
    t_ack = 0;
    t_rsp = 0;
    line = '0;
    beat = '0;
    ifill_req_i.valid = 1'b1;
    ifill_req_i.way = way;
    ifill_req_i.paddr = paddr;
    t0 = cyc;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ifill_resp_o.ack) begin got = 1; t_ack = cyc; end
    end
    ifill_req_i.valid = 1'b0;
    chk({tag, "_ack_seen"}, 256'(got), 256'(1));
    chk({tag, "_ack_lat"}, 256'(t_ack - t0), 256'(1));
    tick();
    chk({tag, "_ack_pulse"}, 256'(ifill_resp_o.ack), 256'(0));
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (ifill_resp_o.valid) begin
        got = 1; t_rsp = cyc; line = ifill_resp_o.data; beat = ifill_resp_o.beat;
      end else begin
        tick();
      end
    end
    chk({tag, "_resp_seen"}, 256'(got), 256'(1));
    chk({tag, "_data"}, line, exp_line);
    chk({tag, "_beat"}, 256'(beat), 256'(s));
    if (chk_lat) chk({tag, "_resp_lat"}, 256'(t_rsp - t0), 256'(6));
    chk({tag, "_n_issue"}, 256'(issue_log.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < issue_log.size())
        chk({tag, "_addr"}, 256'(issue_log[i]), 256'(base + 40'(((s + i) % 4) * 8)));
    end
    tick();
    chk({tag, "_resp_pulse"}, 256'(ifill_resp_o.valid), 256'(0));
    chk({tag, "_overlap"}, 256'(overlap), 256'(0));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_resp", 256'(ifill_resp_o), 256'(0));
    chk("rst_mem_valid", 256'(mem_req_valid_o), 256'(0));
    chk("rst_mem_addr", 256'(mem_req_addr_o), 256'(0));
    rstn_i = 1'b1;
    exp_inv = '0;
    tick();

    // Basic fill, zero-wait memory.
    words[0] = 64'hA0; words[1] = 64'hA1; words[2] = 64'hA2; words[3] = 64'hA3;
    ready_mode = 0; lat = 1; inv_mode = 0;
    fill(40'h80001234, 2'd2, 1'b1, "basic");

    // Backpressure with delayed responses.
    rand_words();
    ready_mode = 1; lat = 3;
    fill({8'h80, 32'($urandom)}, 2'd1, 1'b0, "bp");

    // Invalidations during FETCH and RESP.
    rand_words();
    ready_mode = 0; lat = 1; inv_mode = 1;
    fill({8'h80, 32'($urandom)}, 2'd0, 1'b1, "inv_fill");
    inv_mode = 0;
    tick();

    // Back-to-back fills of the same line with fresh memory contents.
    rand_words();
    inv_mode = 2;
    fill(40'h80002040, 2'd3, 1'b1, "b2b_a");
    rand_words();
    fill(40'h80002040, 2'd3, 1'b1, "b2b_b");
    inv_mode = 0;
    tick();
    tick();

    // Reset in the middle of a fill.
    rand_words();
    rsp_given = 0;
    ifill_req_i.valid = 1'b1;
    ifill_req_i.paddr = 40'h80003300;
    begin
      bit reached = 0;
      for (int i = 0; i < 40 && !reached; i++) begin
        tick();
        if (ifill_resp_o.ack) ifill_req_i.valid = 1'b0;
        if (rsp_given >= 2) reached = 1;
      end
      chk("rst_mid_reach", 256'(reached), 256'(1));
    end
    ifill_req_i.valid = 1'b0;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    inv_valid_i = 1'b0;
    inv_paddr_i = '0;
    #1;
    chk("rst_mid_resp", 256'(ifill_resp_o), 256'(0));
    chk("rst_mid_mem_valid", 256'(mem_req_valid_o), 256'(0));
    chk("rst_mid_mem_addr", 256'(mem_req_addr_o), 256'(0));
    repeat (2) @(negedge clk_i);
    #1;
    rstn_i = 1'b1;
    exp_inv = '0;
    tick();
    rand_words();
    fill({8'h80, 32'($urandom)}, 2'd1, 1'b1, "after_rst");

    // Requested word in the last slot.
    rand_words();
    fill(40'h80001238, 2'd0, 1'b1, "cwf");

    // Randomised memory timing and invalidation traffic.
    for (int k = 0; k < 4; k++) begin
      rand_words();
      ready_mode = 2;
      lat = $urandom_range(1, 4);
      inv_mode = 2;
      fill({8'h80, 32'($urandom)}, 2'($urandom), 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
